// File: rtl/uart_rx_capture.sv
// UART receiver: 2-flop synchroniser, glitch-rejecting start detection, parity/framing
// checks, first-word-fall-through receive FIFO, sticky error flags and a match strobe.
module uart_rx_capture #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                         core_clk,
  input  logic                         core_rstn,
  input  logic                         rx,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_BITS-1:0]         rd_data,
  output logic                         rd_perr,
  output logic                         rd_ferr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic                         match_en,
  input  logic [DATA_BITS-1:0]         match_pattern,
  output logic                         match_hit,
  input  logic                         err_clear,
  output logic                         overflow,
  output logic                         ferr_sticky,
  output logic                         perr_sticky
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF   = CLKS_PER_BIT / 2;
  localparam int unsigned IDX_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W  = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_armed;
  logic                 w_rxs;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 w_half;
  logic                 w_full_bit;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_cnt_run;
  logic                 w_tick;
  logic                 w_frame_clr;
  logic                 w_shift_en;
  logic                 w_par_en;
  logic                 w_stop_en;
  logic                 w_push_en;
  logic                 w_ferr_now;
  logic                 r_push_vld;
  logic [ENT_W-1:0]     r_push_ent;
  logic                 r_match_hit;

  // Synchroniser; r_armed blocks start detection until rxs has been seen high.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      if (r_sync2) r_armed <= 1'b1;
    end
  end

  assign w_rxs       = r_sync2;
  assign w_half      = (r_cnt == CNT_W'(HALF - 1));
  assign w_full_bit  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_data = (r_idx == IDX_W'(DATA_BITS - 1));
  assign w_last_stop = (r_idx == IDX_W'(STOP_BITS - 1));

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_armed && !w_rxs) w_state_nxt = S_START;
      S_START:  if (w_half) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
      S_DATA:   if (w_full_bit && w_last_data) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_full_bit) w_state_nxt = S_STOP;
      S_STOP:   if (w_full_bit && w_last_stop) w_state_nxt = w_rxs ? S_IDLE : S_BREAK;
      S_BREAK:  if (w_rxs) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_run   = 1'b0;
    w_tick      = 1'b0;
    w_frame_clr = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop_en   = 1'b0;
    w_push_en   = 1'b0;
    case (r_state)
      S_IDLE:   w_frame_clr = 1'b1;
      S_START:  begin w_cnt_run = 1'b1; w_tick = w_half; end
      S_DATA:   begin w_cnt_run = 1'b1; w_tick = w_full_bit; w_shift_en = w_full_bit; end
      S_PARITY: begin w_cnt_run = 1'b1; w_tick = w_full_bit; w_par_en = w_full_bit; end
      S_STOP: begin
        w_cnt_run = 1'b1;
        w_tick    = w_full_bit;
        w_stop_en = w_full_bit;
        w_push_en = w_full_bit & w_last_stop;
      end
      default: ;
    endcase
  end

  assign w_ferr_now = r_ferr | ~w_rxs;

  // Bit timing, shift register and per-frame error accumulation.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_push_vld  <= 1'b0;
      r_push_ent  <= '0;
      r_match_hit <= 1'b0;
    end else begin
      if (!w_cnt_run || w_tick) r_cnt <= '0;
      else                      r_cnt <= r_cnt + CNT_W'(1);

      if (w_frame_clr)     r_idx <= '0;
      else if (w_shift_en) r_idx <= w_last_data ? '0 : r_idx + IDX_W'(1);
      else if (w_stop_en)  r_idx <= r_idx + IDX_W'(1);

      if (w_shift_en) r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};

      if (w_frame_clr)   r_perr <= 1'b0;
      else if (w_par_en) r_perr <= (PARITY == 1) ? ~((^r_shift) ^ w_rxs) : ((^r_shift) ^ w_rxs);

      if (w_frame_clr)                r_ferr <= 1'b0;
      else if (w_stop_en && !w_rxs)   r_ferr <= 1'b1;

      r_push_vld <= w_push_en;
      if (w_push_en) r_push_ent <= {w_ferr_now, r_perr, r_shift};
      r_match_hit <= w_push_en & match_en & (r_shift == match_pattern) & ~w_ferr_now & ~r_perr;
    end
  end

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [OCC_W-1:0] r_count;
  logic             r_rd_valid;
  logic [ENT_W-1:0] r_head;
  logic [ENT_W-1:0] w_head_nxt;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             r_overflow;
  logic             r_ferr_sticky;
  logic             r_perr_sticky;

  assign w_full     = (r_wr[ADDR_W] != r_rd[ADDR_W]) && (r_wr[ADDR_W-1:0] == r_rd[ADDR_W-1:0]);
  assign w_pop      = r_rd_valid & rd_ready;
  assign w_push_ok  = r_push_vld & (~w_full | w_pop);
  assign w_wr_nxt   = r_wr + PTR_W'(w_push_ok);
  assign w_rd_nxt   = r_rd + PTR_W'(w_pop);
  // The next head is the entry being written this cycle when the FIFO drains to it.
  assign w_head_nxt = (w_rd_nxt == r_wr) ? r_push_ent : r_mem[w_rd_nxt[ADDR_W-1:0]];

  always_ff @(posedge core_clk) begin
    if (w_push_ok) r_mem[r_wr[ADDR_W-1:0]] <= r_push_ent;
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_count       <= '0;
      r_rd_valid    <= 1'b0;
      r_head        <= '0;
      r_overflow    <= 1'b0;
      r_ferr_sticky <= 1'b0;
      r_perr_sticky <= 1'b0;
    end else begin
      r_wr       <= w_wr_nxt;
      r_rd       <= w_rd_nxt;
      r_count    <= r_count + OCC_W'(w_push_ok) - OCC_W'(w_pop);
      r_rd_valid <= (w_wr_nxt != w_rd_nxt);
      if (w_wr_nxt != w_rd_nxt) r_head <= w_head_nxt;
      r_overflow    <= (r_push_vld & w_full & ~w_pop) | (r_overflow & ~err_clear);
      r_ferr_sticky <= (r_push_vld & r_push_ent[ENT_W-1]) | (r_ferr_sticky & ~err_clear);
      r_perr_sticky <= (r_push_vld & r_push_ent[ENT_W-2]) | (r_perr_sticky & ~err_clear);
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_head[DATA_BITS-1:0];
  assign rd_perr     = r_head[ENT_W-2];
  assign rd_ferr     = r_head[ENT_W-1];
  assign count       = r_count;
  assign match_hit   = r_match_hit;
  assign overflow    = r_overflow;
  assign ferr_sticky = r_ferr_sticky;
  assign perr_sticky = r_perr_sticky;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Scenario bench for uart_rx_capture: even parity, 16 clocks per bit, 4-entry FIFO.
module tb_uart_rx_capture;
  localparam int unsigned CPB    = 16;
  localparam int unsigned DB     = 8;
  localparam int unsigned PAR    = 2;
  localparam int unsigned SB     = 1;
  localparam int unsigned DEP    = 4;
  localparam int unsigned CW     = $clog2(DEP + 1);
  localparam int unsigned FRAME  = CPB * (1 + DB + 1 + SB);
  // Negedge index (counted from the one after rx falls) where rd_valid first reads high.
  localparam int unsigned RISE_N = 2 + CPB/2 + (1 + DB + 1 + SB - 1) * CPB + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          rd_valid;
  logic          rd_ready;
  logic [DB-1:0] rd_data;
  logic          rd_perr;
  logic          rd_ferr;
  logic [CW-1:0] count;
  logic          match_en;
  logic [DB-1:0] match_pattern;
  logic          match_hit;
  logic          err_clear;
  logic          overflow;
  logic          ferr_sticky;
  logic          perr_sticky;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q [$];

  uart_rx_capture #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .DEPTH(DEP)
  ) dut (
    .core_clk(clk), .core_rstn(rst_n), .rx(rx),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_perr(rd_perr), .rd_ferr(rd_ferr), .count(count),
    .match_en(match_en), .match_pattern(match_pattern), .match_hit(match_hit),
    .err_clear(err_clear), .overflow(overflow),
    .ferr_sticky(ferr_sticky), .perr_sticky(perr_sticky)
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Even parity bit, optionally inverted; stop bit value as given.
  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ par_bad);
    send_bit(stop_v);
  endtask

  task automatic pop_one(output bit got, output logic [9:0] ent);
    got = 1'b0;
    ent = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rd_valid) begin
        got = 1'b1;
        ent = {rd_ferr, rd_perr, rd_data};
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; rd_ready = 1'b0; match_en = 1'b0;
    match_pattern = '0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rd_valid, match_hit, overflow, ferr_sticky, perr_sticky, rd_perr, rd_ferr} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {rd_valid, match_hit, overflow, ferr_sticky, perr_sticky, rd_perr, rd_ferr});
    end
    n_cmp++;
    if (rd_data !== 8'h00 || count !== '0) begin
      n_err++;
      $display("FAIL reset_data_count: got data=%h count=%0d expected 00/0", rd_data, count);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [9:0] ent;
    logic [9:0] exp;
    int first_valid = 0;
    int rise [3] = '{0, 0, 0};
    @(posedge clk); #1;
    exp_q.push_back({2'b00, 8'hA5});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'hFF});
    fork
      begin
        send_frame(8'hA5, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
      end
      begin
        int k = 0;
        logic [CW-1:0] last_cnt = '0;
        for (int n = 1; n <= int'(3 * FRAME + 40); n++) begin
          @(negedge clk);
          if (rd_valid && first_valid == 0) first_valid = n;
          if (count != last_cnt) begin
            if (k < 3) rise[k] = n;
            k++;
            last_cnt = count;
          end
        end
      end
    join
    n_cmp++;
    if (first_valid != int'(RISE_N)) begin
      n_err++;
      $display("FAIL b2b_valid_latency: got %0d expected %0d", first_valid, RISE_N);
    end
    for (int f = 0; f < 3; f++) begin
      n_cmp++;
      if (rise[f] != int'(RISE_N + f * FRAME)) begin
        n_err++;
        $display("FAIL b2b_count_step%0d: got %0d expected %0d", f, rise[f], RISE_N + f * FRAME);
      end
    end
    n_cmp++;
    if (count !== CW'(3)) begin
      n_err++;
      $display("FAIL b2b_count: got %0d expected 3", count);
    end
    for (int f = 0; f < 3; f++) begin
      pop_one(got, ent);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!got || ent !== exp) begin
        n_err++;
        $display("FAIL b2b_entry%0d: got valid=%0d ent=%h expected %h", f, got, ent, exp);
      end
    end
    n_cmp++;
    if ({overflow, ferr_sticky, perr_sticky} !== 3'b000) begin
      n_err++;
      $display("FAIL b2b_sticky: got %b expected 000", {overflow, ferr_sticky, perr_sticky});
    end
  endtask

  task automatic test_glitch();
    bit got;
    logic [9:0] ent;
    logic [9:0] exp;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_cmp++;
    if ({rd_valid, overflow, ferr_sticky, perr_sticky} !== 4'b0 || count !== '0) begin
      n_err++;
      $display("FAIL glitch_no_push: got flags=%b count=%0d expected 0000/0",
               {rd_valid, overflow, ferr_sticky, perr_sticky}, count);
    end
    @(posedge clk); #1;
    exp_q.push_back({2'b00, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b1);
    pop_one(got, ent);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || ent !== exp) begin
      n_err++;
      $display("FAIL glitch_recover: got valid=%0d ent=%h expected %h", got, ent, exp);
    end
  endtask

  task automatic test_parity();
    bit got;
    logic [9:0] ent;
    logic [9:0] exp;
    @(posedge clk); #1;
    exp_q.push_back({2'b01, 8'h03});
    send_frame(8'h03, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (perr_sticky !== 1'b1 || ferr_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL parity_sticky: got perr=%b ferr=%b expected 1/0", perr_sticky, ferr_sticky);
    end
    pop_one(got, ent);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || ent !== exp) begin
      n_err++;
      $display("FAIL parity_entry: got valid=%0d ent=%h expected %h", got, ent, exp);
    end
    pulse_clear();
    @(negedge clk);
    n_cmp++;
    if (perr_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL parity_clear: got %b expected 0", perr_sticky);
    end
  endtask

  task automatic test_break();
    bit got;
    logic [9:0] ent;
    logic [9:0] exp;
    @(posedge clk); #1;
    exp_q.push_back({2'b10, 8'h55});
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40 * CPB) @(posedge clk);
    #1;
    n_cmp++;
    if (count !== CW'(1)) begin
      n_err++;
      $display("FAIL break_hold_count: got %0d expected 1", count);
    end
    send_bit(1'b1);
    exp_q.push_back({2'b00, 8'h12});
    send_frame(8'h12, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (count !== CW'(2) || ferr_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL break_count: got count=%0d ferr_sticky=%b expected 2/1", count, ferr_sticky);
    end
    for (int f = 0; f < 2; f++) begin
      pop_one(got, ent);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!got || ent !== exp) begin
        n_err++;
        $display("FAIL break_entry%0d: got valid=%0d ent=%h expected %h", f, got, ent, exp);
      end
    end
    pulse_clear();
  endtask

  task automatic test_overflow();
    bit got;
    logic [9:0] ent;
    logic [9:0] exp;
    logic [9:0] popped = '0;
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({2'b00, bytes[i]});
      send_frame(bytes[i], 1'b0, 1'b1);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (count !== CW'(4) || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full: got count=%0d overflow=%b expected 4/1", count, overflow);
    end
    pulse_clear();
    @(posedge clk); #1;
    fork
      send_frame(8'h66, 1'b0, 1'b1);
      begin
        repeat (RISE_N - 1) @(negedge clk);
        popped = {rd_ferr, rd_perr, rd_data};
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
      end
    join
    exp = exp_q.pop_front();
    exp_q.push_back({2'b00, 8'h66});
    n_cmp++;
    if (popped !== exp) begin
      n_err++;
      $display("FAIL ovf_pop_head: got %h expected %h", popped, exp);
    end
    n_cmp++;
    if (overflow !== 1'b0 || count !== CW'(4)) begin
      n_err++;
      $display("FAIL ovf_simul: got overflow=%b count=%0d expected 0/4", overflow, count);
    end
    for (int f = 0; f < 4; f++) begin
      pop_one(got, ent);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!got || ent !== exp) begin
        n_err++;
        $display("FAIL ovf_entry%0d: got valid=%0d ent=%h expected %h", f, got, ent, exp);
      end
    end
  endtask

  task automatic test_match();
    bit got;
    logic [9:0] ent;
    logic [9:0] exp;
    int hits;
    int hit_n;
    match_en = 1'b1;
    match_pattern = 8'hAB;
    for (int t = 0; t < 2; t++) begin
      hits = 0;
      hit_n = 0;
      @(posedge clk); #1;
      exp_q.push_back({(t == 1), 1'b0, 8'hAB});
      fork
        send_frame(8'hAB, 1'b0, (t == 0));
        for (int n = 1; n <= int'(FRAME + 20); n++) begin
          @(negedge clk);
          if (match_hit) begin
            hits++;
            if (hit_n == 0) hit_n = n;
          end
        end
      join
      rx = 1'b1;
      n_cmp++;
      if (hits != ((t == 0) ? 1 : 0)) begin
        n_err++;
        $display("FAIL match_hits%0d: got %0d expected %0d", t, hits, (t == 0) ? 1 : 0);
      end
      if (t == 0) begin
        n_cmp++;
        if (hit_n != int'(RISE_N - 1)) begin
          n_err++;
          $display("FAIL match_time: got %0d expected %0d", hit_n, RISE_N - 1);
        end
      end
    end
    match_en = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      pop_one(got, ent);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!got || ent !== exp) begin
        n_err++;
        $display("FAIL match_entry%0d: got valid=%0d ent=%h expected %h", f, got, ent, exp);
      end
    end
    pulse_clear();
  endtask

  task automatic test_reset_midframe();
    bit got;
    logic [9:0] ent;
    logic [9:0] exp;
    @(posedge clk); #1;
    send_frame(8'h77, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b0 || count !== '0) begin
      n_err++;
      $display("FAIL midreset_flush: got valid=%b count=%0d expected 0/0", rd_valid, count);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    exp_q.push_back({2'b00, 8'h81});
    send_frame(8'h81, 1'b0, 1'b1);
    pop_one(got, ent);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || ent !== exp) begin
      n_err++;
      $display("FAIL midreset_recover: got valid=%0d ent=%h expected %h", got, ent, exp);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_parity();
    test_break();
    test_overflow();
    test_match();
    test_reset_midframe();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b0 || count !== '0) begin
      n_err++;
      $display("FAIL final_empty: got valid=%b count=%0d expected 0/0", rd_valid, count);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_capture.md
# uart_rx_capture

Synthesizable, parametrised UART receiver with a receive FIFO, per-byte error tagging and a pattern-match strobe, clocked from the management core clock. It is the successor to the behavioural bit-time UART monitor used in the SoC benches. It can sit inside the FPGA build as an on-chip serial capture and debug checker, or in simulation as a cycle-accurate monitor of `ser_tx`. Unlike the behavioural monitor, it supports configurable frame format, buffering, back-pressure, glitch rejection and error reporting.

## Interface
Parameters:
- `CLKS_PER_BIT`, 104: core clocks per UART bit. Must be 8 or greater. 104 gives 115200 baud at 12 MHz.
- `DATA_BITS`, 8: data bits per frame, range 5–9, sent LSB first.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits, 1 or 2.
- `DEPTH`, 16: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `core_clk` in 1: the single clock.
- `core_rstn` in 1: reset, asynchronous and active-low.
- `rx` in 1: serial input. Asynchronous to `core_clk`; idles high.
- `rd_valid` out 1: the FIFO head is valid.
- `rd_ready` in 1: consumer accepts the head.
- `rd_data` out DATA_BITS: data of the head entry.
- `rd_perr` out 1: parity error flag of the head entry.
- `rd_ferr` out 1: framing error flag of the head entry.
- `count` out $clog2(DEPTH+1): current FIFO occupancy.
- `match_en` in 1: enables pattern matching.
- `match_pattern` in DATA_BITS: value to compare against received bytes.
- `match_hit` out 1: one-cycle pulse on a matching, error-free byte.
- `err_clear` in 1: clears the sticky error flags.
- `overflow` out 1: sticky. A frame was dropped because the FIFO was full.
- `ferr_sticky` out 1: sticky framing error.
- `perr_sticky` out 1: sticky parity error.

## Operation
- `rx` passes through a 2-flop synchroniser that resets to 1. All logic below uses the synchronised value `rxs`.
- The FSM states are IDLE, START, DATA, PARITY, STOP, BREAK. There is one bit counter of width $clog2(CLKS_PER_BIT) and one bit index.
- IDLE: when `rxs` = 0, go to START with counter = 0.
- START: when the counter reaches CLKS_PER_BIT/2−1, sample `rxs`. If 1, the start was a glitch: go back to IDLE with no push and no error. If 0, go to DATA and reload the counter.
- DATA: sample `rxs` every CLKS_PER_BIT clocks, which is mid-bit, and shift LSB first. After DATA_BITS samples, go to PARITY, or to STOP when PARITY = 0.
- PARITY: take one sample. `perr` = 1 when the XOR of the data and the parity bit is 0 for odd mode, or 1 for even mode.
- STOP: sample each stop bit. `ferr` = 1 if any stop sample is 0. After the last stop sample:
  - Attempt a push of {ferr, perr, data}.
  - Go to IDLE if the final stop sample is 1.
  - Otherwise go to BREAK. BREAK waits for `rxs` = 1 and then goes to IDLE. No new start bit is detected while in BREAK.
- Push:
  - If `count` < DEPTH, write the entry.
  - Otherwise drop the frame and set `overflow`. When the FIFO is full, a pop and a push in the same cycle succeed with no overflow.
- `ferr_sticky` and `perr_sticky` set whenever the corresponding flag is pushed or dropped.
- `err_clear` clears all three sticky flags. If a set event occurs in the same cycle, set wins.
- The FIFO is first-word-fall-through. `rd_*` show the head while `rd_valid` = 1. A pop happens when `rd_valid & rd_ready`.
  - When the FIFO is empty, a push is not visible on `rd_valid` until the next cycle.
  - `rd_ready` while `rd_valid` = 0 has no effect.
- Pointers have $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full is detected as MSBs differ and the remaining bits are equal.
- `match_hit` pulses in the push-attempt cycle when `match_en` = 1, data equals `match_pattern`, ferr = 0 and perr = 0. This happens whether or not the push succeeds.

## Timing
- Reset values: `rd_valid`, `match_hit`, `overflow`, `ferr_sticky`, `perr_sticky` = 0; `count` = 0; `rd_data`, `rd_perr`, `rd_ferr` = 0; FSM = IDLE; synchroniser = 1.
- Reset asserted mid-frame aborts the frame and flushes the FIFO. After release, the first start bit is detected only after `rxs` has been seen high for at least 1 cycle.
- Latency: the push-attempt cycle is the cycle after the last stop sample. `rd_valid` rises 1 cycle after the push-attempt cycle.
  - The last stop sample lies 2 synchroniser cycles + (CLKS_PER_BIT/2) + (1+DATA_BITS+P+STOP_BITS−1)·CLKS_PER_BIT after the falling edge of `rx`, where P = 1 if PARITY ≠ 0, else 0. The 1 in the frame term counts the start bit.
- The maximum sustained rate is back-to-back frames with no idle between them. The receiver is ready for a new start one cycle after the last stop sample.

## Test plan
- Default parameters at CLKS_PER_BIT=16: send 0xA5, 0x00, 0xFF back-to-back → three entries in order, all flags 0, `count` reaches 3, each `rd_valid` rises at the specified latency.
- Hold `rx` low for 4 clocks → no push, FSM returns to IDLE, no sticky flag set.
- PARITY=2: send 0x03 with parity bit 1 → entry with `rd_perr`=1, `perr_sticky`=1. Assert `err_clear` → `perr_sticky`=0.
- Send 0x55 with stop bit 0, then hold `rx` low for 40 bit times, then resume with 0x12 → entry 0x55 with `rd_ferr`=1, no spurious frames, then entry 0x12 clean.
- DEPTH=4 with `rd_ready`=0: send 5 bytes → `count`=4 and `overflow`=1 with the 5th dropped. Then send a 6th byte while popping in the same cycle as its push → no additional drop.
- `match_en`=1, `match_pattern`=0xAB: send 0xAB clean → `match_hit` high for exactly 1 cycle. Send 0xAB with a framing error → no `match_hit`.
